dspba_delay_elastic: RTL and testbench

Multi-lane, fixed-depth pipeline delay line with per-stage valid tracking, valid/ready backpressure, bubble collapsing, synchronous flush and an occupancy count. It is the successor to the plain enable-driven delay line in the FP-core datapath. It sits between DSPBA-generated arithmetic stages and the FPU issue and writeback logic wherever a delay must tolerate downstream stalls without losing data.

---
 rtl/dspba_delay_pkg.sv | 24 ++
 rtl/dspba_delay_skid.sv | 41 ++++
 rtl/dspba_delay_elastic.sv | 137 +++++++++++++
 tb/tb_dspba_delay_elastic.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/dspba_delay_pkg.sv
// Shared sizing helpers for the elastic delay line.
// Defining DSPBA_DELAY_SKID_EN adds a one-entry skid after the last stage.
package dspba_delay_pkg;

`ifdef DSPBA_DELAY_SKID_EN
  localparam int SKID_EN = 1;
`else
  localparam int SKID_EN = 0;
`endif

  // Occupancy counter width for a given depth; clamped to 1 bit so a
  // zero-depth pass-through still has a legal port.
  function automatic int occ_width(input int depth, input int skid);
    int cap;
    cap = (depth > 0) ? depth + skid : 0;
    return (cap < 1) ? 1 : $clog2(cap + 1);
  endfunction

  // LSB of lane k in a packed LANES*WIDTH bus.
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/dspba_delay_skid.sv
// One-entry skid buffer; only compiled with DSPBA_DELAY_SKID_EN.
// An empty skid is bypassed combinationally; it captures the head on a stall.
`ifdef DSPBA_DELAY_SKID_EN
module dspba_delay_skid #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         aclr,
  input  logic         flush,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready
);

  logic         skid_v;
  logic [W-1:0] skid_d;

  // Ready depends only on the skid register, breaking the ready path.
  assign in_ready  = !skid_v;
  assign out_valid = skid_v || in_valid;
  assign out_data  = skid_v ? skid_d : in_data;

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      skid_v <= 1'b0;
      skid_d <= '0;
    end else if (flush) begin
      skid_v <= 1'b0;
    end else if (skid_v) begin
      if (out_ready) skid_v <= 1'b0;
    end else if (in_valid && !out_ready) begin
      skid_v <= 1'b1;
      skid_d <= in_data;
    end
  end

endmodule
`endif

// File: rtl/dspba_delay_elastic.sv
// Multi-lane fixed-depth delay line with valid/ready backpressure, bubble
// collapsing, flush and occupancy. Optional skid: DSPBA_DELAY_SKID_EN.
module dspba_delay_elastic
  import dspba_delay_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int LANES = 1,
  parameter  int DEPTH = 2,
  localparam int OCC_W = occ_width(DEPTH, SKID_EN)
) (
  input  logic                   clk,
  input  logic                   aclr,
  input  logic                   flush,
  input  logic                   in_valid,
  input  logic [LANES*WIDTH-1:0] in_data,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [LANES*WIDTH-1:0] out_data,
  input  logic                   out_ready,
  output logic [OCC_W-1:0]       occupancy
);

  // Handshake: a transfer happens on a rising edge where valid && ready are
  // both high; valid never waits on ready, and data is only meaningful with valid.

  if (DEPTH == 0) begin : g_pass
    assign out_valid = in_valid;
    assign out_data  = in_data;
    assign in_ready  = out_ready;
    assign occupancy = '0;
  end else begin : g_pipe
    logic [DEPTH-1:0]       v;
    logic [WIDTH-1:0]       d      [DEPTH][LANES];
    logic [DEPTH-1:0]       up_v;
    logic [WIDTH-1:0]       up_d   [DEPTH][LANES];
    logic [DEPTH-1:0]       stage_rdy;
    logic                   head_rdy;
    logic [LANES*WIDTH-1:0] head_d;
    logic [OCC_W-1:0]       occ_q;
    logic                   in_hs;
    logic                   out_hs;

    always_comb begin
      up_v = '0;
      for (int i = 0; i < DEPTH; i++) begin
        for (int k = 0; k < LANES; k++) up_d[i][k] = '0;
      end
      up_v[0] = in_valid;
      for (int k = 0; k < LANES; k++) begin
        up_d[0][k] = in_data[lane_lsb(k, WIDTH) +: WIDTH];
      end
      for (int i = 1; i < DEPTH; i++) begin
        up_v[i] = v[i-1];
        for (int k = 0; k < LANES; k++) up_d[i][k] = d[i-1][k];
      end
    end

    // A stage is ready unless it and every stage downstream of it are full
    // while the head is blocked; invalid stages always load, collapsing bubbles.
    always_comb begin
      logic all_full;
      all_full  = 1'b1;
      stage_rdy = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
        all_full     = all_full && v[i];
        stage_rdy[i] = head_rdy || !all_full;
      end
    end

    always_comb begin
      head_d = '0;
      for (int k = 0; k < LANES; k++) begin
        head_d[lane_lsb(k, WIDTH) +: WIDTH] = d[DEPTH-1][k];
      end
    end

    always_ff @(posedge clk or negedge aclr) begin
      if (!aclr) begin
        v <= '0;
        for (int i = 0; i < DEPTH; i++) begin
          for (int k = 0; k < LANES; k++) d[i][k] <= '0;
        end
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (flush) begin
            v[i] <= 1'b0;
          end else if (stage_rdy[i]) begin
            v[i] <= up_v[i];
            if (up_v[i]) begin
              for (int k = 0; k < LANES; k++) d[i][k] <= up_d[i][k];
            end
          end
        end
      end
    end

`ifdef DSPBA_DELAY_SKID_EN
    dspba_delay_skid #(
      .W(LANES * WIDTH)
    ) u_skid (
      .clk      (clk),
      .aclr     (aclr),
      .flush    (flush),
      .in_valid (v[DEPTH-1]),
      .in_data  (head_d),
      .in_ready (head_rdy),
      .out_valid(out_valid),
      .out_data (out_data),
      .out_ready(out_ready)
    );
`else
    assign head_rdy  = out_ready;
    assign out_valid = v[DEPTH-1];
    assign out_data  = head_d;
`endif

    // Flush blocks acceptance so nothing slips in behind the clear.
    assign in_ready = stage_rdy[0] && !flush;
    assign in_hs    = in_valid && in_ready;
    assign out_hs   = out_valid && out_ready;

    always_ff @(posedge clk or negedge aclr) begin
      if (!aclr) begin
        occ_q <= '0;
      end else if (flush) begin
        occ_q <= '0;
      end else if (in_hs && !out_hs) begin
        occ_q <= occ_q + OCC_W'(1);
      end else if (!in_hs && out_hs) begin
        occ_q <= occ_q - OCC_W'(1);
      end
    end

    assign occupancy = occ_q;
  end

endmodule

// File: tb/tb_dspba_delay_elastic.sv
// Directed bench for dspba_delay_elastic (LANES=2, WIDTH=8); the
// DSPBA_DELAY_SKID_EN build runs the skid scenario at DEPTH=2 instead.
module tb_dspba_delay_elastic;

`ifdef DSPBA_DELAY_SKID_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 3;
`endif
  localparam int CAP   = 3;
  localparam int WIDTH = 8;
  localparam int LANES = 2;
  localparam int DW    = LANES * WIDTH;
  localparam int OCC_W = $clog2(CAP + 1);

  logic             clk = 1'b0;
  logic             aclr;
  logic             flush;
  logic             in_valid;
  logic [DW-1:0]    in_data;
  logic             in_ready;
  logic             out_valid;
  logic [DW-1:0]    out_data;
  logic             out_ready;
  logic [OCC_W-1:0] occupancy;

  logic [DW-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  dspba_delay_elastic #(
    .WIDTH(WIDTH),
    .LANES(LANES),
    .DEPTH(DEPTH)
  ) dut (
    .clk      (clk),
    .aclr     (aclr),
    .flush    (flush),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  // Lane 1 carries the complement of lane 0 so lane swaps are visible.
  function automatic logic [DW-1:0] pk(input logic [7:0] val);
    return {~val, val};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // One clock cycle: drive inputs just after an edge, check the settled
  // outputs, then advance past the next edge. Expected accepts feed exp_q.
  task automatic step(input string tag, input logic iv, input logic [7:0] val,
                      input logic ordy, input logic fl, input logic exp_ir,
                      input logic exp_ov, input int exp_occ);
    in_valid  = iv;
    in_data   = pk(val);
    out_ready = ordy;
    flush     = fl;
    #1;
    check({tag, ".in_ready"}, 32'(in_ready), 32'(exp_ir));
    check({tag, ".out_valid"}, 32'(out_valid), 32'(exp_ov));
    check({tag, ".occupancy"}, 32'(occupancy), 32'(exp_occ));
    if (exp_ov) begin
      if (exp_q.size() == 0) begin
        check({tag, ".scoreboard_empty"}, 32'(out_data), 32'hdead);
      end else if (ordy) begin
        check({tag, ".out_data"}, 32'(out_data), 32'(exp_q.pop_front()));
      end else begin
        check({tag, ".out_data_held"}, 32'(out_data), 32'(exp_q[0]));
      end
    end
    if (fl) exp_q.delete();
    else if (iv && exp_ir) exp_q.push_back(pk(val));
    @(posedge clk);
    #1;
  endtask

  initial begin
    aclr      = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset.out_valid", 32'(out_valid), 32'd0);
    check("reset.out_data", 32'(out_data), 32'd0);
    check("reset.occupancy", 32'(occupancy), 32'd0);
    @(negedge clk);
    aclr = 1'b1;
    @(posedge clk);
    #1;
    check("reset.in_ready", 32'(in_ready), 32'd1);

`ifndef DSPBA_DELAY_SKID_EN
    // Back-to-back stream: head after 3 cycles, one per cycle, peak occupancy 3.
    step("s0", 1, 8'h11, 1, 0, 1, 0, 0);
    step("s1", 1, 8'h22, 1, 0, 1, 0, 1);
    step("s2", 1, 8'h33, 1, 0, 1, 0, 2);
    step("s3", 1, 8'h44, 1, 0, 1, 1, 3);
    step("s4", 1, 8'h55, 1, 0, 1, 1, 3);
    step("s5", 0, 8'h00, 1, 0, 1, 1, 3);
    step("s6", 0, 8'h00, 1, 0, 1, 1, 2);
    step("s7", 0, 8'h00, 1, 0, 1, 1, 1);
    step("s8", 0, 8'h00, 1, 0, 1, 0, 0);

    // Stalled gapped input fills all three stages; then full-rate release.
    step("g0", 1, 8'ha1, 0, 0, 1, 0, 0);
    step("g1", 0, 8'h00, 0, 0, 1, 0, 1);
    step("g2", 1, 8'ha2, 0, 0, 1, 0, 1);
    step("g3", 0, 8'h00, 0, 0, 1, 1, 2);
    step("g4", 1, 8'ha3, 0, 0, 1, 1, 2);
    step("g5", 1, 8'ha4, 0, 0, 0, 1, 3);
    step("g6", 1, 8'ha4, 1, 0, 1, 1, 3);
    step("g7", 1, 8'ha5, 1, 0, 1, 1, 3);
    step("g8", 1, 8'ha6, 1, 0, 1, 1, 3);
    step("g9", 0, 8'h00, 1, 0, 1, 1, 3);
    step("g10", 0, 8'h00, 1, 0, 1, 1, 2);
    step("g11", 0, 8'h00, 1, 0, 1, 1, 1);
    step("g12", 0, 8'h00, 1, 0, 1, 0, 0);

    // Flush with two entries in flight; the input offered during flush is dropped.
    step("f0", 1, 8'hb1, 0, 0, 1, 0, 0);
    step("f1", 0, 8'h00, 0, 0, 1, 0, 1);
    step("f2", 1, 8'hb2, 0, 0, 1, 0, 1);
    step("f3", 1, 8'hb3, 0, 1, 0, 1, 2);
    step("f4", 0, 8'h00, 1, 0, 1, 0, 0);
    step("f5", 1, 8'hb4, 1, 0, 1, 0, 0);
    step("f6", 0, 8'h00, 1, 0, 1, 0, 1);
    step("f7", 0, 8'h00, 1, 0, 1, 0, 1);
    step("f8", 0, 8'h00, 1, 0, 1, 1, 1);
    step("f9", 0, 8'h00, 1, 0, 1, 0, 0);

    // Asynchronous reset mid-stream, then normal latency afterwards.
    step("a0", 1, 8'hc1, 1, 0, 1, 0, 0);
    step("a1", 1, 8'hc2, 1, 0, 1, 0, 1);
    step("a2", 1, 8'hc3, 1, 0, 1, 0, 2);
    in_valid = 1'b0;
    check("aclr.pre_out_valid", 32'(out_valid), 32'd1);
    aclr = 1'b0;
    #1;
    check("aclr.out_valid", 32'(out_valid), 32'd0);
    check("aclr.out_data", 32'(out_data), 32'd0);
    check("aclr.occupancy", 32'(occupancy), 32'd0);
    exp_q.delete();
    @(negedge clk);
    aclr = 1'b1;
    @(posedge clk);
    #1;
    step("d0", 1, 8'hd1, 1, 0, 1, 0, 0);
    step("d1", 0, 8'h00, 1, 0, 1, 0, 1);
    step("d2", 0, 8'h00, 1, 0, 1, 0, 1);
    step("d3", 0, 8'h00, 1, 0, 1, 1, 1);
    step("d4", 0, 8'h00, 1, 0, 1, 0, 0);
`else
    // Skid at DEPTH=2: three entries held, registered ready, one-cycle out_ready pulse.
    step("k0", 1, 8'he1, 0, 0, 1, 0, 0);
    step("k1", 1, 8'he2, 0, 0, 1, 0, 1);
    step("k2", 1, 8'he3, 0, 0, 1, 1, 2);
    step("k3", 1, 8'he4, 0, 0, 0, 1, 3);
    step("k4", 1, 8'he4, 1, 0, 0, 1, 3);
    step("k5", 1, 8'he4, 0, 0, 1, 1, 2);
    step("k6", 0, 8'h00, 1, 0, 0, 1, 3);
    step("k7", 0, 8'h00, 1, 0, 1, 1, 2);
    step("k8", 0, 8'h00, 1, 0, 1, 1, 1);
    step("k9", 0, 8'h00, 1, 0, 1, 0, 0);
    step("k10", 1, 8'hf1, 1, 0, 1, 0, 0);
    step("k11", 0, 8'h00, 1, 0, 1, 0, 1);
    step("k12", 0, 8'h00, 1, 0, 1, 1, 1);
    step("k13", 0, 8'h00, 1, 0, 1, 0, 0);
`endif

    check("final.scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
